// File: rtl/gray_burst_ctrl.sv
// rtl/gray_burst_ctrl.sv - round-robin burst scheduler driving a shared Gray-code counter
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   req    per-requester level request, held until the matching done
//   len0   burst length for requester 0, sampled at grant
//   len1   burst length for requester 1, sampled at grant
//   gnt    one-hot registered grant, 00 when idle
//   done   one-cycle pulse to the owner in the burst-end cycle
//   busy   high whenever the scheduler is not idle
//   en     counter enable, high exactly in RUN cycles
//   q      registered Gray count of the persistent binary counter
module gray_burst_ctrl #(
    parameter int WIDTH = 32,
    parameter int LENW  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LENW-1:0]  len0,
    input  logic [LENW-1:0]  len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             en,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] bin, bin_nx;
    logic [LENW-1:0]  rem, rem_nx;
    logic             ptr, ptr_nx;
    logic [1:0]       gnt_nx, done_nx;
    logic             winner;
    logic [LENW-1:0]  win_len;

    always_comb begin
        state_nx = state;
        bin_nx   = bin;
        rem_nx   = rem;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        done_nx  = 2'b00;
        // With both requests pending the pointer decides; otherwise the lone requester wins.
        winner   = (req == 2'b11) ? ptr : req[1];
        win_len  = winner ? len1 : len0;
        case (state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_nx = winner ? 2'b10 : 2'b01;
                    rem_nx = win_len;
                    if (win_len != '0) begin
                        state_nx = S_RUN;
                    end else begin
                        // Zero-length burst skips RUN; done lines up with the DONE cycle.
                        state_nx = S_DONE;
                        done_nx  = gnt_nx;
                    end
                end
            end
            S_RUN: begin
                bin_nx = bin + WIDTH'(1);
                rem_nx = rem - LENW'(1);
                if (rem == LENW'(1)) begin
                    state_nx = S_DONE;
                    done_nx  = gnt;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                gnt_nx   = 2'b00;
                // Prefer the requester that was not just served.
                ptr_nx   = gnt[0];
            end
            default: begin
                state_nx = S_IDLE;
                gnt_nx   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            bin   <= '0;
            q     <= '0;
            rem   <= '0;
            ptr   <= 1'b0;
            gnt   <= 2'b00;
            done  <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            bin   <= bin_nx;
            // q is the Gray image of the next binary value, so it tracks bin with no extra lag.
            q     <= bin_nx ^ (bin_nx >> 1);
            rem   <= rem_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            busy  <= (state_nx != S_IDLE);
        end
    end

    assign en = (state == S_RUN);

endmodule
